// File: rtl/mont_mul_cios_pkg.sv
// Shared definitions for the word-serial CIOS Montgomery multiplier.
//   MONT_WORD_W        default digit width (radix 2^MONT_WORD_W)
//   MONT_WIDTH         default operand width
//   mont_cios_state_t  controller states
//   ED448_P            Ed448 field prime 2^448 - 2^224 - 1
//   ED448_P_INV_WORD   -p^-1 mod 2^64 for ED448_P (p = -1 mod 2^64, so this is 1)
package mont_mul_cios_pkg;

    localparam int MONT_WORD_W = 64;
    localparam int MONT_WIDTH  = 448;

    typedef enum logic [2:0] {
        IDLE,
        CALC_M,
        ACCUM,
        FINAL,
        DONE
    } mont_cios_state_t;

    localparam logic [447:0] ED448_P          = {{223{1'b1}}, 1'b0, {224{1'b1}}};
    localparam logic [63:0]  ED448_P_INV_WORD = 64'd1;

endpackage

// File: rtl/mont_word_step.sv
// One CIOS outer-iteration update: t_next = (t + a*b_i + m*p) >> WORD_W.
// Purely combinational so it can be exercised alone or pipelined later.
//   t       in  WIDTH+1  running accumulator
//   a       in  WIDTH    multiplicand
//   b_i     in  WORD_W   current digit of the multiplier
//   m       in  WORD_W   reduction digit for this iteration
//   p       in  WIDTH    modulus
//   t_next  out WIDTH+1  shifted sum
module mont_word_step #(
    parameter int WIDTH  = 448,
    parameter int WORD_W = 64
) (
    input  logic [WIDTH:0]    t,
    input  logic [WIDTH-1:0]  a,
    input  logic [WORD_W-1:0] b_i,
    input  logic [WORD_W-1:0] m,
    input  logic [WIDTH-1:0]  p,
    output logic [WIDTH:0]    t_next
);

    localparam int SUM_W = WIDTH + WORD_W + 2;

    logic [SUM_W-1:0] sum;
    logic             sum_unused;

    assign sum = SUM_W'(t) + SUM_W'(a) * SUM_W'(b_i) + SUM_W'(m) * SUM_W'(p);

    // m is chosen so the low digit cancels, and t < 2p keeps the top bit clear;
    // neither slice carries information.
    assign t_next     = sum[WIDTH+WORD_W:WORD_W];
    assign sum_unused = ^{sum[WORD_W-1:0], sum[SUM_W-1]};

endmodule

// File: rtl/mont_mul_cios.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*2^-WIDTH mod p.
// One WORD_W-bit digit of b is consumed per CALC_M/ACCUM pair; done appears
// 2*NUM_WORDS+3 cycles after the accept edge's cycle begins.
// Optional build macro MONT_MUL_OPERAND_CHECK_EN enables the err range flag;
// otherwise err is constant 0.
//   clk, rst  clock, synchronous active-high reset
//   start     request, sampled only in IDLE
//   a, b      operands (< p), p odd modulus, p_inv = -p^-1 mod 2^WORD_W
//   busy      high from accept until done
//   result    product, held until next accept
//   done      one-cycle completion pulse
//   err       operand-range flag
module mont_mul_cios
    import mont_mul_cios_pkg::*;
#(
    parameter int WIDTH  = MONT_WIDTH,
    parameter int WORD_W = MONT_WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [WIDTH-1:0]  p,
    input  logic [WORD_W-1:0] p_inv,
    output logic              busy,
    output logic [WIDTH-1:0]  result,
    output logic              done,
    output logic              err
);

    localparam int NUM_WORDS = WIDTH / WORD_W;
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    mont_cios_state_t state, state_nx;

    logic [WIDTH-1:0]  a_r, b_r, p_r;
    logic [WORD_W-1:0] p_inv_r, m_r, m_calc;
    logic [WIDTH:0]    t_r, t_step, t_sub;
    logic [WIDTH-1:0]  final_val;
    logic [CNT_W-1:0]  i_r;
    logic              accept, last_word, fin_unused;

    assign accept    = (state == IDLE) && start;
    assign last_word = (i_r == CNT_W'(NUM_WORDS - 1));

    // b_r is shifted down each iteration, so its low digit is always b_i.
    assign m_calc = (t_r[WORD_W-1:0] + a_r[WORD_W-1:0] * b_r[WORD_W-1:0]) * p_inv_r;

    mont_word_step #(
        .WIDTH  (WIDTH),
        .WORD_W (WORD_W)
    ) u_step (
        .t      (t_r),
        .a      (a_r),
        .b_i    (b_r[WORD_W-1:0]),
        .m      (m_r),
        .p      (p_r),
        .t_next (t_step)
    );

    // t < 2p, so one conditional subtraction brings it into [0, p).
    assign t_sub      = t_r - {1'b0, p_r};
    assign final_val  = (t_r >= {1'b0, p_r}) ? t_sub[WIDTH-1:0] : t_r[WIDTH-1:0];
    assign fin_unused = t_sub[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = CALC_M;
            CALC_M:  state_nx = ACCUM;
            ACCUM:   state_nx = last_word ? FINAL : CALC_M;
            FINAL:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            t_r    <= '0;
            i_r    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        p_r     <= p;
                        p_inv_r <= p_inv;
                        t_r     <= '0;
                        i_r     <= '0;
                        busy    <= 1'b1;
                    end
                end
                CALC_M: m_r <= m_calc;
                ACCUM: begin
                    t_r <= t_step;
                    b_r <= b_r >> WORD_W;
                    i_r <= i_r + CNT_W'(1);
                end
                FINAL: result <= final_val;
                DONE: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef MONT_MUL_OPERAND_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)         err <= 1'b0;
        else if (accept) err <= (a >= p) | (b >= p) | ~p[0];
    end
`else
    logic accept_unused;
    assign accept_unused = accept;
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_mont_mul_cios.sv
module tb_mont_mul_cios;

    localparam int WIDTH  = 16;
    localparam int WORD_W = 8;
    localparam logic [15:0] P    = 16'hFFF1;
    localparam logic [7:0]  PINV = 8'hEF;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] a, b, p;
    logic [7:0]  p_inv;
    logic        busy, done, err;
    logic [15:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mont_mul_cios #(.WIDTH(WIDTH), .WORD_W(WORD_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .p      (p),
        .p_inv  (p_inv),
        .busy   (busy),
        .result (result),
        .done   (done),
        .err    (err)
    );

    // a*b*R^-1 mod p with R^-1 = 0xEEE1 (15 * 0xEEE1 = 1 mod 0xFFF1)
    function automatic logic [15:0] model(input logic [15:0] x, input logic [15:0] y);
        longint unsigned xx, yy, pr;
        xx = x;
        yy = y;
        pr = (xx * yy) % 65521;
        return 16'((pr * 61153) % 65521);
    endfunction

    // Called at a negedge with the DUT idle. Returns at the negedge where done
    // is first seen; lat is the edge index (accept edge = 0), -1 on timeout.
    task automatic run_op(input logic [15:0] ai, input logic [15:0] bi, input bit poke,
                          output logic [15:0] res, output int lat);
        start = 1'b1; a = ai; b = bi;
        @(posedge clk); @(negedge clk);
        start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
        lat = -1;
        res = 16'h0;
        for (int k = 1; k <= 40; k++) begin
            if (poke && k == 2) begin
                start = 1'b1; a = 16'h000F; b = 16'h000F;
            end else if (poke && k == 3) begin
                start = 1'b0;
            end
            @(posedge clk); @(negedge clk);
            if (done) begin
                lat = k;
                res = result;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; p = P; p_inv = PINV;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
        n_cmp++; if (err !== 1'b0)     begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL reset_result got %h want 0000", result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [15:0] r; int lat;
        run_op(16'h0001, 16'h0001, 1'b0, r, lat);
        n_cmp++; if (r !== 16'hEEE1) begin n_bad++; $display("FAIL basic_result got %h want eee1", r); end
        n_cmp++; if (lat !== 6)      begin n_bad++; $display("FAIL basic_latency got %0d want 6", lat); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0)  begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
        n_cmp++; if (busy !== 1'b0)  begin n_bad++; $display("FAIL basic_busy_after got %b want 0", busy); end
    endtask

    task automatic test_vectors;
        logic [15:0] r; int lat;
        run_op(16'h000F, 16'h000F, 1'b0, r, lat);
        n_cmp++; if (r !== 16'h000F) begin n_bad++; $display("FAIL mont_one got %h want 000f", r); end
        run_op(16'hFFF0, 16'hFFF0, 1'b0, r, lat);
        n_cmp++; if (r !== 16'hEEE1) begin n_bad++; $display("FAIL final_sub got %h want eee1", r); end
        n_cmp++; if (lat !== 6)      begin n_bad++; $display("FAIL final_sub_latency got %0d want 6", lat); end
        run_op(16'h0000, 16'h1234, 1'b0, r, lat);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL zero_a got %h want 0000", r); end
        run_op(16'h1234, 16'h0000, 1'b0, r, lat);
        n_cmp++; if (r !== 16'h0000) begin n_bad++; $display("FAIL zero_b got %h want 0000", r); end
    endtask

    task automatic test_ignore_start;
        logic [15:0] r; int lat;
        run_op(16'h0001, 16'h0001, 1'b1, r, lat);
        n_cmp++; if (r !== 16'hEEE1) begin n_bad++; $display("FAIL ignore_start got %h want eee1", r); end
        n_cmp++; if (lat !== 6)      begin n_bad++; $display("FAIL ignore_start_latency got %0d want 6", lat); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] r1, r2; int l1, l2;
        run_op(16'h0002, 16'h0003, 1'b0, r1, l1);
        run_op(16'h000F, 16'h1234, 1'b0, r2, l2);
        n_cmp++; if (r1 !== model(16'h0002, 16'h0003)) begin n_bad++; $display("FAIL b2b_first got %h want %h", r1, model(16'h0002, 16'h0003)); end
        n_cmp++; if (r2 !== 16'h1234) begin n_bad++; $display("FAIL b2b_second got %h want 1234", r2); end
        n_cmp++; if (l2 !== 6)        begin n_bad++; $display("FAIL b2b_latency got %0d want 6", l2); end
    endtask

    task automatic test_reset_mid;
        logic [15:0] r; int lat; bit seen_done;
        start = 1'b1; a = 16'hFFF0; b = 16'h1234;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy_before got %b want 1", busy); end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (busy !== 1'b0)    begin n_bad++; $display("FAIL mid_busy got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0)    begin n_bad++; $display("FAIL mid_done got %b want 0", done); end
        n_cmp++; if (result !== 16'h0) begin n_bad++; $display("FAIL mid_result got %h want 0000", result); end
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        n_cmp++; if (seen_done !== 1'b0) begin n_bad++; $display("FAIL mid_no_done got %b want 0", seen_done); end
        run_op(16'h1234, 16'h5678, 1'b0, r, lat);
        n_cmp++; if (r !== model(16'h1234, 16'h5678)) begin n_bad++; $display("FAIL mid_recover got %h want %h", r, model(16'h1234, 16'h5678)); end
    endtask

    task automatic test_err;
        logic [15:0] r; int lat; logic exp_err;
`ifdef MONT_MUL_OPERAND_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        run_op(P, 16'h0001, 1'b0, r, lat);
        n_cmp++; if (err !== exp_err) begin n_bad++; $display("FAIL err_a_eq_p got %b want %b", err, exp_err); end
        n_cmp++; if (lat !== 6)       begin n_bad++; $display("FAIL err_latency got %0d want 6", lat); end
        run_op(16'h0001, 16'h0001, 1'b0, r, lat);
        n_cmp++; if (err !== 1'b0)    begin n_bad++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_random;
        logic [15:0] x, y, r; int lat;
        for (int n = 0; n < 16; n++) begin
            x = 16'($urandom_range(0, 32'hFFF0));
            y = 16'($urandom_range(0, 32'hFFF0));
            run_op(x, y, 1'b0, r, lat);
            n_cmp++;
            if (r !== model(x, y) || lat !== 6) begin
                n_bad++;
                $display("FAIL random a=%h b=%h got %h lat %0d want %h lat 6", x, y, r, lat, model(x, y));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_err();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
